// File: rtl/dcache_pkg.sv
// Shared class encoding and geometry helpers for the n-way DRAM-cache tag comparator.
package dcache_pkg;

  typedef enum logic [1:0] {
    RHIT,
    RMISS,
    WHIT,
    WMISS
  } access_class_e;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned index_w,
                                            input int unsigned offset_w);
    return addr_w - index_w - offset_w;
  endfunction

  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/dcache_way_select.sv
// Combinational way selection: hit vector, lowest-way hit, multi-hit detect,
// and invalid-first / round-robin victim choice.
module dcache_way_select
  import dcache_pkg::*;
#(
  parameter  int unsigned WAYS      = 2,
  parameter  int unsigned TAG_WIDTH = 16,
  localparam int unsigned WAY_BITS  = way_bits(WAYS)
) (
  input  logic [TAG_WIDTH-1:0]      tag_i,
  input  logic [WAYS-1:0]           valid_i,
  input  logic [WAYS*TAG_WIDTH-1:0] tags_i,
  input  logic [WAY_BITS-1:0]       rr_ptr_i,
  output logic                      hit_o,
  output logic [WAY_BITS-1:0]       hit_way_o,
  output logic                      multi_hit_o,
  output logic [WAY_BITS-1:0]       victim_way_o,
  output logic                      all_valid_o
);

  logic [WAYS-1:0]     hit_vec;
  logic                hit_found;
  logic                inv_found;
  logic [WAY_BITS-1:0] inv_way;

  always_comb begin
    hit_vec = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_i[w] && (tags_i[w*TAG_WIDTH +: TAG_WIDTH] == tag_i);
    end
  end

  always_comb begin
    hit_way_o = '0;
    hit_found = 1'b0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit_found && hit_vec[w]) begin
        hit_way_o = WAY_BITS'(w);
        hit_found = 1'b1;
      end
      if (!inv_found && !valid_i[w]) begin
        inv_way   = WAY_BITS'(w);
        inv_found = 1'b1;
      end
    end
  end

  // More than one bit set iff clearing the lowest set bit leaves something.
  assign multi_hit_o  = |(hit_vec & (hit_vec - WAYS'(1)));
  assign hit_o        = |hit_vec;
  assign all_valid_o  = &valid_i;
  assign victim_way_o = all_valid_o ? rr_ptr_i : inv_way;

endmodule

// File: rtl/dcache_tag_compare_nway.sv
// N-way DRAM-cache tag comparator: pairs response beats with pending requests and
// issues hit / fill / writeback traffic. Optional DCACHE_TAG_STATS_EN adds counters.
module dcache_tag_compare_nway
  import dcache_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH   = 32,
  parameter  int unsigned DATA_WIDTH   = 64,
  parameter  int unsigned TID_WIDTH    = 4,
  parameter  int unsigned WAYS         = 2,
  parameter  int unsigned INDEX_WIDTH  = 10,
  parameter  int unsigned OFFSET_WIDTH = 6,
  localparam int unsigned TAG_WIDTH    = tag_width(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH),
  localparam int unsigned WAY_BITS     = way_bits(WAYS),
  localparam int unsigned ENTRY_W      = 2 + TAG_WIDTH + DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WAYS*ENTRY_W-1:0]       rdata_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,
  input  logic                          req_empty_i,
  output logic                          req_rden_o,
  input  logic [1+TID_WIDTH+ADDR_WIDTH-1:0] req_data_i,
  input  logic                          rob_afull_i,
  output logic                          rob_wren_o,
  output logic [TID_WIDTH+DATA_WIDTH-1:0] rob_data_o,
  input  logic                          ar_fifo_afull_i,
  output logic                          ar_fifo_wren_o,
  output logic [TID_WIDTH+ADDR_WIDTH-1:0] ar_fifo_data_o,
  input  logic                          fix_fifo_afull_i,
  output logic                          fix_fifo_wren_o,
  output logic [WAY_BITS+ADDR_WIDTH-1:0] fix_fifo_data_o,
  input  logic                          aw_fifo_afull_i,
  output logic                          aw_fifo_wren_o,
  output logic [ADDR_WIDTH-1:0]         aw_fifo_data_o,
  input  logic                          w_fifo_afull_i,
  output logic                          w_fifo_wren_o,
  output logic [DATA_WIDTH-1:0]         w_fifo_data_o,
  output logic [WAY_BITS-1:0]           victim_way_o,
  output logic                          err_multi_hit_o
`ifdef DCACHE_TAG_STATS_EN
  ,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   miss_cnt_o,
  output logic [31:0]                   wb_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_ISSUE
  } state_e;

  typedef struct packed {
    logic                  is_write;
    logic [TID_WIDTH-1:0]  tid;
    logic [ADDR_WIDTH-1:0] addr;
  } req_t;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [TAG_WIDTH-1:0] tag;
  } tag_entry_t;

  state_e                  state_q, state_d;
  req_t                    req_q;
  logic [WAYS*ENTRY_W-1:0] beat_q;
  access_class_e           cls_q, cls_d;
  logic [WAY_BITS-1:0]     hit_way_q, victim_q, rr_ptr_q, rr_ptr_nxt;
  logic                    need_wb_q, need_wb_d, rr_adv_q, err_q;

  logic [WAYS-1:0]           valid_v, dirty_v;
  logic [WAYS*TAG_WIDTH-1:0] tags_v;
  logic [TAG_WIDTH-1:0]      tag_v  [WAYS];
  logic [DATA_WIDTH-1:0]     data_v [WAYS];
  logic [TAG_WIDTH-1:0]      req_tag;

  logic                sel_hit, sel_multi, sel_all_valid;
  logic [WAY_BITS-1:0] sel_hit_way, sel_victim;

  logic accept, fire, miss_q, use_rob, use_fix, use_wb, sinks_ok;

  logic [TID_WIDTH+DATA_WIDTH-1:0] rob_new, rob_data_q;
  logic [TID_WIDTH+ADDR_WIDTH-1:0] ar_new, ar_data_q;
  logic [WAY_BITS+ADDR_WIDTH-1:0]  fix_new, fix_data_q;
  logic [ADDR_WIDTH-1:0]           aw_new, aw_data_q;
  logic [DATA_WIDTH-1:0]           w_new, w_data_q;
  logic [WAY_BITS-1:0]             victim_way_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_unpack
    tag_entry_t ent;
    assign ent        = beat_q[w*ENTRY_W + DATA_WIDTH +: 2 + TAG_WIDTH];
    assign valid_v[w] = ent.valid;
    assign dirty_v[w] = ent.dirty;
    assign tag_v[w]   = ent.tag;
    assign tags_v[w*TAG_WIDTH +: TAG_WIDTH] = ent.tag;
    assign data_v[w]  = beat_q[w*ENTRY_W +: DATA_WIDTH];
  end

  assign req_tag = req_q.addr[ADDR_WIDTH-1 -: TAG_WIDTH];

  dcache_way_select #(
    .WAYS      (WAYS),
    .TAG_WIDTH (TAG_WIDTH)
  ) u_way_select (
    .tag_i        (req_tag),
    .valid_i      (valid_v),
    .tags_i       (tags_v),
    .rr_ptr_i     (rr_ptr_q),
    .hit_o        (sel_hit),
    .hit_way_o    (sel_hit_way),
    .multi_hit_o  (sel_multi),
    .victim_way_o (sel_victim),
    .all_valid_o  (sel_all_valid)
  );

  assign rready_o   = (state_q == S_IDLE) && !req_empty_i;
  assign req_rden_o = rvalid_i && rready_o;
  assign accept     = req_rden_o;

  always_comb begin
    if (req_q.is_write) cls_d = sel_hit ? WHIT : WMISS;
    else                cls_d = sel_hit ? RHIT : RMISS;
  end

  assign need_wb_d  = !sel_hit && valid_v[sel_victim] && dirty_v[sel_victim];
  assign rr_ptr_nxt = (rr_ptr_q == WAY_BITS'(WAYS - 1)) ? '0 : rr_ptr_q + WAY_BITS'(1);

  assign miss_q  = (cls_q == RMISS) || (cls_q == WMISS);
  assign use_rob = (cls_q == RHIT);
  assign use_fix = (cls_q == WHIT);
  assign use_wb  = miss_q && need_wb_q;

  // A clean miss only depends on the AR sink; evict sinks gate only writebacks.
  assign sinks_ok = !(use_rob && rob_afull_i) &&
                    !(use_fix && fix_fifo_afull_i) &&
                    !(miss_q  && ar_fifo_afull_i) &&
                    !(use_wb  && (aw_fifo_afull_i || w_fifo_afull_i));
  assign fire = (state_q == S_ISSUE) && sinks_ok;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_CMP;
      S_CMP:   state_d = S_ISSUE;
      S_ISSUE: if (fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rob_new = {req_q.tid, data_v[hit_way_q]};
  assign ar_new  = {req_q.tid, req_q.addr};
  assign fix_new = {hit_way_q, req_q.addr};
  assign aw_new  = {tag_v[victim_q], req_q.addr[OFFSET_WIDTH +: INDEX_WIDTH], {OFFSET_WIDTH{1'b0}}};
  assign w_new   = data_v[victim_q];

  // Payloads are presented in the issue cycle and held afterwards without a bubble.
  assign rob_wren_o      = fire && use_rob;
  assign fix_fifo_wren_o = fire && use_fix;
  assign ar_fifo_wren_o  = fire && miss_q;
  assign aw_fifo_wren_o  = fire && use_wb;
  assign w_fifo_wren_o   = fire && use_wb;

  assign rob_data_o      = rob_wren_o      ? rob_new  : rob_data_q;
  assign fix_fifo_data_o = fix_fifo_wren_o ? fix_new  : fix_data_q;
  assign ar_fifo_data_o  = ar_fifo_wren_o  ? ar_new   : ar_data_q;
  assign aw_fifo_data_o  = aw_fifo_wren_o  ? aw_new   : aw_data_q;
  assign w_fifo_data_o   = w_fifo_wren_o   ? w_new    : w_data_q;
  assign victim_way_o    = ar_fifo_wren_o  ? victim_q : victim_way_q;
  assign err_multi_hit_o = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      req_q        <= '0;
      beat_q       <= '0;
      cls_q        <= RHIT;
      hit_way_q    <= '0;
      victim_q     <= '0;
      need_wb_q    <= 1'b0;
      rr_adv_q     <= 1'b0;
      rr_ptr_q     <= '0;
      err_q        <= 1'b0;
      rob_data_q   <= '0;
      ar_data_q    <= '0;
      fix_data_q   <= '0;
      aw_data_q    <= '0;
      w_data_q     <= '0;
      victim_way_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q  <= req_t'(req_data_i);
        beat_q <= rdata_i;
      end
      if (state_q == S_CMP) begin
        cls_q     <= cls_d;
        hit_way_q <= sel_hit_way;
        victim_q  <= sel_victim;
        need_wb_q <= need_wb_d;
        rr_adv_q  <= !sel_hit && sel_all_valid;
        if (sel_multi) err_q <= 1'b1;
      end
      if (fire) begin
        if (use_rob) rob_data_q <= rob_new;
        if (use_fix) fix_data_q <= fix_new;
        if (miss_q) begin
          ar_data_q    <= ar_new;
          victim_way_q <= victim_q;
          if (rr_adv_q) rr_ptr_q <= rr_ptr_nxt;
        end
        if (use_wb) begin
          aw_data_q <= aw_new;
          w_data_q  <= w_new;
        end
      end
    end
  end

`ifdef DCACHE_TAG_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else if (fire) begin
      if (!miss_q && hit_cnt_q != '1)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_q && miss_cnt_q != '1)  miss_cnt_q <= miss_cnt_q + 32'd1;
      if (use_wb && wb_cnt_q != '1)    wb_cnt_q   <= wb_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_tag_compare_nway.sv
// Randomized self-checking bench for dcache_tag_compare_nway (default geometry, 2 ways).
module tb_dcache_tag_compare_nway;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int TW  = 4;
  localparam int NW  = 2;
  localparam int IW  = 10;
  localparam int OW  = 6;
  localparam int TGW = AW - IW - OW;
  localparam int WB  = 1;
  localparam int EW  = 2 + TGW + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NW*EW-1:0]   rdata_i = '0;
  logic               rvalid_i = 1'b0, rready_o;
  logic               req_empty_i = 1'b1, req_rden_o;
  logic [1+TW+AW-1:0] req_data_i = '0;
  logic               rob_afull_i = 1'b0, rob_wren_o;
  logic [TW+DW-1:0]   rob_data_o;
  logic               ar_fifo_afull_i = 1'b0, ar_fifo_wren_o;
  logic [TW+AW-1:0]   ar_fifo_data_o;
  logic               fix_fifo_afull_i = 1'b0, fix_fifo_wren_o;
  logic [WB+AW-1:0]   fix_fifo_data_o;
  logic               aw_fifo_afull_i = 1'b0, aw_fifo_wren_o;
  logic [AW-1:0]      aw_fifo_data_o;
  logic               w_fifo_afull_i = 1'b0, w_fifo_wren_o;
  logic [DW-1:0]      w_fifo_data_o;
  logic [WB-1:0]      victim_way_o;
  logic               err_multi_hit_o;

  dcache_tag_compare_nway #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .TID_WIDTH    (TW),
    .WAYS         (NW),
    .INDEX_WIDTH  (IW),
    .OFFSET_WIDTH (OW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rdata_i          (rdata_i),
    .rvalid_i         (rvalid_i),
    .rready_o         (rready_o),
    .req_empty_i      (req_empty_i),
    .req_rden_o       (req_rden_o),
    .req_data_i       (req_data_i),
    .rob_afull_i      (rob_afull_i),
    .rob_wren_o       (rob_wren_o),
    .rob_data_o       (rob_data_o),
    .ar_fifo_afull_i  (ar_fifo_afull_i),
    .ar_fifo_wren_o   (ar_fifo_wren_o),
    .ar_fifo_data_o   (ar_fifo_data_o),
    .fix_fifo_afull_i (fix_fifo_afull_i),
    .fix_fifo_wren_o  (fix_fifo_wren_o),
    .fix_fifo_data_o  (fix_fifo_data_o),
    .aw_fifo_afull_i  (aw_fifo_afull_i),
    .aw_fifo_wren_o   (aw_fifo_wren_o),
    .aw_fifo_data_o   (aw_fifo_data_o),
    .w_fifo_afull_i   (w_fifo_afull_i),
    .w_fifo_wren_o    (w_fifo_wren_o),
    .w_fifo_data_o    (w_fifo_data_o),
    .victim_way_o     (victim_way_o),
    .err_multi_hit_o  (err_multi_hit_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction under test and per-way contents of the response beat.
  bit            t_w;
  bit [TW-1:0]   t_tid;
  bit [AW-1:0]   t_addr;
  bit            wv   [NW];
  bit            wd   [NW];
  bit [TGW-1:0]  wt   [NW];
  bit [DW-1:0]   wdat [NW];

  // Reference model: round-robin pointer, sticky error, last payload of every sink.
  int            m_rr;
  bit            m_err;
  logic [TW+DW-1:0] m_rob;
  logic [TW+AW-1:0] m_ar;
  logic [WB+AW-1:0] m_fix;
  logic [AW-1:0]    m_aw;
  logic [DW-1:0]    m_w;
  logic [WB-1:0]    m_vic;

  // Sink order in masks: {rob, ar, fix, aw, w}.
  task automatic set_afull(input bit [4:0] m);
    {rob_afull_i, ar_fifo_afull_i, fix_fifo_afull_i, aw_fifo_afull_i, w_fifo_afull_i} = m;
  endtask

  task automatic model_reset();
    m_rr = 0; m_err = 0; m_rob = '0; m_ar = '0; m_fix = '0; m_aw = '0; m_w = '0; m_vic = '0;
  endtask

  task automatic set_way(input int w, input bit v, input bit d, input bit [TGW-1:0] t, input bit [DW-1:0] dat);
    wv[w] = v; wd[w] = d; wt[w] = t; wdat[w] = dat;
  endtask

  function automatic logic [NW*EW-1:0] pack_beat();
    logic [NW*EW-1:0] b;
    b = '0;
    for (int w = 0; w < NW; w++) b[w*EW +: EW] = {wv[w], wd[w], wt[w], wdat[w]};
    return b;
  endfunction

  task automatic check_outputs(input string ph, input bit [4:0] exp_wr);
    chk_eq({ph, ".wren"}, {rob_wren_o, ar_fifo_wren_o, fix_fifo_wren_o, aw_fifo_wren_o, w_fifo_wren_o}, exp_wr);
    chk_eq({ph, ".rready"}, rready_o, 0);
    chk_eq({ph, ".rden"}, req_rden_o, 0);
    chk_eq({ph, ".rob_data"}, rob_data_o, m_rob);
    chk_eq({ph, ".ar_data"}, ar_fifo_data_o, m_ar);
    chk_eq({ph, ".fix_data"}, fix_fifo_data_o, m_fix);
    chk_eq({ph, ".aw_data"}, aw_fifo_data_o, m_aw);
    chk_eq({ph, ".w_data"}, w_fifo_data_o, m_w);
    chk_eq({ph, ".victim"}, victim_way_o, m_vic);
    chk_eq({ph, ".err"}, err_multi_hit_o, m_err);
  endtask

  // Presents the request and beat in an idle cycle; returns #1 after the accept edge.
  task automatic start_txn(input string ph);
    req_data_i  = {t_w, t_tid, t_addr};
    rdata_i     = pack_beat();
    req_empty_i = 1'b0;
    rvalid_i    = 1'b1;
    set_afull(5'b0);
    @(negedge clk);
    chk_eq({ph, ".rready_idle"}, rready_o, 1);
    chk_eq({ph, ".rden_idle"}, req_rden_o, 1);
    @(posedge clk);
    #1;
  endtask

  // k stall cycles with afull pattern 'mask' applied from the first issue cycle.
  task automatic do_txn(input string ph, input int k, input bit [4:0] mask);
    int nh, hw, vic, fire_c;
    bit all_v;
    bit [4:0] used;
    bit [TGW-1:0] rtag;
    nh = 0; hw = -1; vic = -1; all_v = 1'b1; used = '0;
    rtag = t_addr[AW-1 -: TGW];
    for (int w = 0; w < NW; w++) begin
      if (wv[w] && wt[w] == rtag) begin
        nh++;
        if (hw < 0) hw = w;
      end
      if (!wv[w]) all_v = 1'b0;
    end
    if (nh == 0) begin
      for (int w = 0; w < NW; w++) if (!wv[w] && vic < 0) vic = w;
      if (vic < 0) vic = m_rr;
      used = 5'b01000;
      if (wv[vic] && wd[vic]) used = used | 5'b00011;
    end else begin
      used = t_w ? 5'b00100 : 5'b10000;
    end
    fire_c = 2 + (((mask & used) != 0) ? k : 0);

    start_txn(ph);
    for (int c = 1; c <= fire_c + 1; c++) begin
      if (c <= fire_c) begin
        rvalid_i    = 1'($urandom);
        req_empty_i = 1'($urandom);
        req_data_i  = {$urandom, $urandom};
        rdata_i     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        set_afull((c >= 2 && c < 2 + k) ? mask : 5'b0);
      end else begin
        rvalid_i    = 1'b0;
        req_empty_i = 1'b1;
        set_afull(5'b0);
      end
      @(negedge clk);
      if (c == 2 && nh > 1) m_err = 1'b1;
      if (c == fire_c) begin
        if (used[4]) m_rob = {t_tid, wdat[hw]};
        if (used[2]) m_fix = {WB'(hw), t_addr};
        if (used[3]) begin
          m_ar  = {t_tid, t_addr};
          m_vic = WB'(vic);
          if (all_v) m_rr = (m_rr + 1) % NW;
        end
        if (used[1]) begin
          m_aw = (AW'(wt[vic]) << (IW + OW)) | (t_addr & AW'(((1 << IW) - 1) << OW));
          m_w  = wdat[vic];
        end
      end
      check_outputs(ph, (c == fire_c) ? used : 5'b0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string ph);
    chk_eq({ph, ".wren"}, {rob_wren_o, ar_fifo_wren_o, fix_fifo_wren_o, aw_fifo_wren_o, w_fifo_wren_o}, 0);
    chk_eq({ph, ".rready"}, rready_o, 0);
    chk_eq({ph, ".rden"}, req_rden_o, 0);
    chk_eq({ph, ".data"}, {rob_data_o, ar_fifo_data_o, fix_fifo_data_o}, 0);
    chk_eq({ph, ".evict"}, {aw_fifo_data_o, w_fifo_data_o}, 0);
    chk_eq({ph, ".victim"}, victim_way_o, 0);
    chk_eq({ph, ".err"}, err_multi_hit_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    for (int w = 0; w < NW; w++) set_way(w, 0, 0, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read hit on way 1.
    t_w = 0; t_tid = 4'h3; t_addr = 32'h0001_2340;
    set_way(0, 0, 0, 16'h0000, 64'h1111);
    set_way(1, 1, 0, 16'h0001, 64'hAB);
    do_txn("rd_hit", 0, 5'b0);

    // Write miss into invalid way 0; a dirty bit on an invalid way must not evict,
    // and evict-side backpressure must not delay a clean miss.
    t_w = 1; t_tid = 4'h5; t_addr = 32'h0005_6780;
    set_way(0, 0, 1, 16'h0777, 64'h2222);
    set_way(1, 1, 1, 16'h1234, 64'h3333);
    do_txn("wr_miss", 4, 5'b00011);

    // Dirty read misses with all ways valid: round-robin victims 0 then 1.
    t_w = 0; t_tid = 4'h9; t_addr = 32'h00AB_CDC0;
    set_way(0, 1, 1, 16'h1111, 64'hDEAD_BEEF_0000_0001);
    set_way(1, 1, 1, 16'h2222, 64'hCAFE_F00D_0000_0002);
    do_txn("rd_miss_wb0", 0, 5'b0);
    do_txn("rd_miss_wb1", 0, 5'b0);

    // Write hit on way 1 held off by the fix FIFO for 5 cycles.
    t_w = 1; t_tid = 4'h2; t_addr = 32'h0042_0100;
    set_way(0, 1, 0, 16'h0041, 64'h4444);
    set_way(1, 1, 1, 16'h0042, 64'h5555);
    do_txn("wr_hit_stall", 5, 5'b00100);

    // Multi-hit resolves to way 0; the error flag stays set across a clean hit.
    t_w = 0; t_tid = 4'hA; t_addr = 32'h0077_0040;
    set_way(0, 1, 0, 16'h0077, 64'h6666);
    set_way(1, 1, 0, 16'h0077, 64'h7777);
    do_txn("multi_hit", 0, 5'b0);
    set_way(0, 1, 0, 16'h0070, 64'h8888);
    do_txn("clean_after_multi", 0, 5'b0);

    // Beat offered with no pending request is not accepted.
    req_empty_i = 1'b1;
    rvalid_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_eq("no_req.rready", rready_o, 0);
      chk_eq("no_req.rden", req_rden_o, 0);
      @(posedge clk);
      #1;
    end
    rvalid_i = 1'b0;

    // Reset while stalled in issue.
    t_w = 0; t_tid = 4'h6; t_addr = 32'h0033_0000;
    set_way(0, 1, 1, 16'h0033, 64'h9999);
    set_way(1, 0, 0, 16'h0000, 64'hAAAA);
    start_txn("rst_issue");
    req_empty_i = 1'b1;
    rvalid_i    = 1'b0;
    set_afull(5'b11111);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_all_zero("rst_issue");
    model_reset();
    rst_n = 1'b1;
    set_afull(5'b0);
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      bit [TGW-1:0] rt;
      t_w    = 1'($urandom);
      t_tid  = TW'($urandom);
      t_addr = $urandom;
      rt     = t_addr[AW-1 -: TGW];
      for (int w = 0; w < NW; w++)
        set_way(w, 1'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0) ? rt : TGW'($urandom),
                {$urandom, $urandom});
      do_txn("rand", $urandom_range(0, 4), 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
